rr_lock_arbiter: RTL
====================

Name: rr_lock_arbiter

Overview:
- Round-robin arbiter with grant locking: shares one resource (bus port, memory port, shared datapath) among N_REQ requesters.
- The grant is held until the owner releases it, drops its request, or a hold timeout expires.
- The grant is presented both one-hot (gnt) and binary (gnt_idx), so downstream muxes can use either form.
- Sits between requesting masters and a shared slave-side mux.

Parameters:
- N_REQ, 4, number of requesters; must be >= 2.
- W_IDX, $clog2(N_REQ), width of binary grant index; leave at default.
- MAX_HOLD, 0, maximum cycles a grant may be held; 0 = unlimited; otherwise 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  per-requester request; level, held until served or abandoned.
- release  input  1  owner signals end of tenure; sampled only when gnt_valid=1.
- gnt  output  N_REQ  one-hot grant, registered; all-zero when idle.
- gnt_valid  output  1  high when gnt is nonzero.
- gnt_idx  output  W_IDX  binary index of granted requester; 0 when idle.
- timeout  output  1  one-cycle pulse: grant revoked by MAX_HOLD expiry.

Behaviour:
- Reset: one clock; synchronous, active-high. On rst: gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, ptr=0, hold counter=0, state IDLE. Reset asserted mid-tenure drops the grant on the next edge with no release needed.
- State: IDLE (no owner) and OWNED (gnt has exactly one bit set). gnt_valid = |gnt, registered, never glitches.
- Priority pointer ptr (W_IDX bits): requester ptr has highest priority, then ptr+1, and so on, wrapping modulo N_REQ (not modulo 2^W_IDX). On each grant to index k, ptr <= (k+1) mod N_REQ.
- Arbitration: winner = first set bit of req scanning from ptr upward with wrap.
  - Implement as masked and unmasked find-first: use the masked result if nonzero, else the unmasked one.
- IDLE -> OWNED: if req != 0, gnt <= onehot(winner) on the next edge. Grant latency is 1 cycle from req assertion.
- OWNED -> end of tenure when any of the following holds in a cycle:
  - release=1;
  - req[owner]=0 (abandon);
  - MAX_HOLD != 0 and hold counter == MAX_HOLD-1.
- End-of-tenure arbitration: in the ending cycle, re-arbitrate with the owner's req bit masked out and ptr already treated as owner+1.
  - If another request is pending, the new gnt is registered on the next edge. This is a zero-bubble handover.
  - Otherwise go to IDLE.
  - The old owner may be re-granted only via a later arbitration, which then gives it lowest priority.
- Hold counter: reset to 0 on every new grant; increments each OWNED cycle; saturates, never wraps.
- timeout: asserted for exactly the cycle after a MAX_HOLD expiry ends a tenure, coincident with the new gnt or with gnt=0. Never asserted when MAX_HOLD=0.
- release while IDLE: ignored. release coinciding with timeout expiry counts as a normal release, so timeout stays 0.
- gnt_idx: registered together with gnt, so the two are always consistent. It is the binary encoding of gnt.
- Simultaneous requests in IDLE: the lowest index at or above ptr wins; no starvation. Any continuously requesting master is granted within N_REQ-1 tenures.
- New req edges during OWNED do not affect gnt until end of tenure.

Decomposition:
- Shared package holds nothing beyond the W_IDX derivation helper; no typedefs needed.
- Sub-module: the codebase's existing onehot_encoder, instantiated to derive the next gnt_idx from the next one-hot grant, then registered.
- Find-first-from-pointer logic stays in this module as a function.

Test Plan:
- Reset/idle: rst high 3 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_idx=0 throughout. First cycle after rst low: gnt=0001 one edge later, gnt_idx=0.
- Round-robin fairness: req=1111 held, release pulsed each OWNED cycle -> gnt sequence 0001,0010,0100,1000,0001 with no idle cycle between grants.
- Wrap with sparse requests: ptr=3, req=4'b0101 -> gnt=0001; after release -> gnt=0100; pointer wraps correctly for N_REQ=3 build (req=3'b101, owner 2 -> next 0).
- Abandon: owner 1 drops req[1] while req=4'b1000 pending, no release -> next edge gnt=1000, timeout=0.
- Timeout: MAX_HOLD=5, req=0011, owner 0 never releases -> gnt=0001 for exactly 5 cycles, then gnt=0010 with timeout=1 for one cycle.
- Reset mid-tenure: owner 2 active, rst pulsed 1 cycle -> gnt=0 next edge. After rst, req=0100 -> re-granted from ptr=0 priority.

Source files
------------

// File: rtl/rr_lock_arbiter_pkg.sv
// Shared definitions for the round-robin lock arbiter.
// Only the binary grant-index width derivation lives here.
package rr_lock_arbiter_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Converts a one-hot vector to its binary index.
// An all-zero input encodes to zero.
module onehot_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | W'(i);
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks the grant to one owner until release,
// abandon or hold timeout, with zero-bubble handover to the next requester.
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int W_IDX    = idx_width(N_REQ),
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             release_gnt,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [W_IDX-1:0] gnt_idx,
  output logic             timeout
);

  localparam int HOLD_W = 16;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t              state_reg, state_next;
  logic [N_REQ-1:0]    gnt_reg, gnt_next;
  logic [W_IDX-1:0]    idx_reg, idx_next;
  logic [W_IDX-1:0]    ptr_reg, ptr_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                valid_reg;
  logic                timeout_reg, timeout_next;
  logic                new_grant;
  logic [N_REQ-1:0]    winner;
  logic                owner_req, expire, tenure_end;

  // Masked find-first from p upward; falls back to unmasked scan to wrap.
  function automatic logic [N_REQ-1:0] pick_first(input logic [N_REQ-1:0] r,
                                                  input logic [W_IDX-1:0] p);
    logic [N_REQ-1:0] masked, hit_m, hit_u;
    logic fm, fu;
    masked = '0;
    hit_m  = '0;
    hit_u  = '0;
    fm     = 1'b0;
    fu     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i >= int'(p)) masked[i] = r[i];
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (masked[i] && !fm) begin
        hit_m[i] = 1'b1;
        fm       = 1'b1;
      end
      if (r[i] && !fu) begin
        hit_u[i] = 1'b1;
        fu       = 1'b1;
      end
    end
    return fm ? hit_m : hit_u;
  endfunction

  // ptr already points at owner+1, so masking the owner's bit is all that
  // end-of-tenure arbitration needs; gnt_reg is zero while idle.
  assign winner     = pick_first(req & ~gnt_reg, ptr_reg);
  assign owner_req  = |(req & gnt_reg);
  assign expire     = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);
  assign tenure_end = release_gnt || !owner_req || expire;

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
    new_grant     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next      = winner;
          state_next    = OWNED;
          hold_cnt_next = '0;
          new_grant     = 1'b1;
        end
      end
      OWNED: begin
        if (tenure_end) begin
          timeout_next = expire && !release_gnt && owner_req;
          if (|winner) begin
            gnt_next      = winner;
            hold_cnt_next = '0;
            new_grant     = 1'b1;
          end else begin
            gnt_next   = '0;
            state_next = IDLE;
          end
        end else if (hold_cnt_reg != '1) begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  onehot_encoder #(
    .N (N_REQ),
    .W (W_IDX)
  ) u_enc (
    .onehot (gnt_next),
    .idx    (idx_next)
  );

  always_comb begin
    ptr_next = ptr_reg;
    if (new_grant) begin
      ptr_next = (idx_next == W_IDX'(N_REQ - 1)) ? '0 : idx_next + W_IDX'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      idx_reg      <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      valid_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      idx_reg      <= idx_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      valid_reg    <= |gnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = valid_reg;
  assign gnt_idx   = idx_reg;
  assign timeout   = timeout_reg;

endmodule
